// File: rtl/dcache_miss_ctrl_if.sv
// Bundles the pipeline, cache-array, memory and perf signals of the data-cache miss controller.
// slave: the controller side. master: the surrounding pipeline/cache/memory environment.
interface dcache_miss_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  stall;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rdata_valid;
    logic                  cache_hit;
    logic [DATA_WIDTH-1:0] cache_rdata;
    logic                  cache_we;
    logic                  fill_en;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [31:0]           perf_misses;
    logic [31:0]           perf_stall_cycles;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, cache_hit, cache_rdata,
               mem_req_ready, mem_resp_valid, mem_rdata,
        output stall, rdata, rdata_valid, cache_we, fill_en, fill_addr, fill_data,
               mem_req_valid, mem_we, mem_addr, mem_wdata, perf_misses, perf_stall_cycles
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, cache_hit, cache_rdata,
               mem_req_ready, mem_resp_valid, mem_rdata,
        input  stall, rdata, rdata_valid, cache_we, fill_en, fill_addr, fill_data,
               mem_req_valid, mem_we, mem_addr, mem_wdata, perf_misses, perf_stall_cycles
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Read-miss / write-through sequencer for the two-way data cache; one memory transaction at a time.
// Optional perf counters are built when DCACHE_MISS_CTRL_PERF_EN is defined, otherwise tied to 0.
module dcache_miss_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    dcache_miss_ctrl_if.slave bus
);
    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_FILL,
        S_WR_REQ
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_lat_addr;
    logic [DATA_WIDTH-1:0] r_lat_wdata;
    logic [DATA_WIDTH-1:0] r_lat_data;
    logic                  w_stall;
    logic                  w_lat_req;
    logic                  w_lat_data;

    // State and latch registers; the request is captured only when leaving IDLE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
            r_lat_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_lat_req) begin
                r_lat_addr  <= bus.req_addr;
                r_lat_wdata <= bus.req_wdata;
            end
            if (w_lat_data) begin
                r_lat_data <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_stall           = 1'b0;
        w_lat_req         = 1'b0;
        w_lat_data        = 1'b0;
        bus.rdata         = '0;
        bus.rdata_valid   = 1'b0;
        bus.cache_we      = 1'b0;
        bus.fill_en       = 1'b0;
        bus.fill_addr     = '0;
        bus.fill_data     = '0;
        bus.mem_req_valid = 1'b0;
        bus.mem_we        = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_we) begin
                        bus.cache_we = 1'b1;
                        w_stall      = 1'b1;
                        w_lat_req    = 1'b1;
                        w_next_state = S_WR_REQ;
                    end else if (bus.cache_hit) begin
                        bus.rdata       = bus.cache_rdata;
                        bus.rdata_valid = 1'b1;
                    end else begin
                        w_stall      = 1'b1;
                        w_lat_req    = 1'b1;
                        w_next_state = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_addr      = r_lat_addr;
                w_stall           = 1'b1;
                if (bus.mem_req_ready) begin
                    w_next_state = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                w_stall = 1'b1;
                if (bus.mem_resp_valid) begin
                    w_lat_data   = 1'b1;
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                bus.fill_en     = 1'b1;
                bus.fill_addr   = r_lat_addr;
                bus.fill_data   = r_lat_data;
                bus.rdata       = r_lat_data;
                bus.rdata_valid = 1'b1;
                w_next_state    = S_IDLE;
            end
            S_WR_REQ: begin
                bus.mem_req_valid = 1'b1;
                bus.mem_we        = 1'b1;
                bus.mem_addr      = r_lat_addr;
                bus.mem_wdata     = r_lat_wdata;
                // The pipeline is released in the handshake cycle itself
                if (bus.mem_req_ready) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign bus.stall = w_stall;

`ifdef DCACHE_MISS_CTRL_PERF_EN
    logic                 w_miss;
    logic [CNT_WIDTH-1:0] r_perf_misses;
    logic [CNT_WIDTH-1:0] r_perf_stall;

    assign w_miss = (r_state == S_IDLE) && (w_next_state == S_RD_REQ);

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_perf_misses <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_miss && (r_perf_misses != '1)) begin
                r_perf_misses <= r_perf_misses + CNT_WIDTH'(1);
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.perf_misses       = r_perf_misses;
    assign bus.perf_stall_cycles = r_perf_stall;
`else
    assign bus.perf_misses       = '0;
    assign bus.perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Bench for dcache_miss_ctrl: directed scenarios with literal expectations plus a random phase,
// all cross-checked every cycle against a transaction-level model of the controller.
module tb_dcache_miss_ctrl;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
`ifdef DCACHE_MISS_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_miss_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dcache_miss_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: an accepted op is pending until its memory side completes;
    // a completed read spends exactly one cycle being returned/filled.
    bit          m_started = 1'b0;
    bit          m_pending = 1'b0;
    bit          m_is_store = 1'b0;
    bit          m_accepted = 1'b0;
    bit          m_returning = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_data = '0;
    int unsigned m_misses = 0;
    int unsigned m_stalls = 0;

    typedef struct {
        logic        stall, rvalid, cwe, fen, mval, mwe;
        logic [31:0] rdata, faddr, fdata, maddr, mwdata;
    } exp_t;

    function automatic exp_t model_out();
        exp_t e;
        e = '{stall: 1'b0, rvalid: 1'b0, cwe: 1'b0, fen: 1'b0, mval: 1'b0, mwe: 1'b0,
              rdata: '0, faddr: '0, fdata: '0, maddr: '0, mwdata: '0};
        if (m_returning) begin
            e.fen = 1'b1; e.faddr = m_addr; e.fdata = m_data;
            e.rvalid = 1'b1; e.rdata = m_data;
        end else if (!m_pending) begin
            if (bus.req_valid && bus.req_we) begin
                e.cwe = 1'b1; e.stall = 1'b1;
            end else if (bus.req_valid && bus.cache_hit) begin
                e.rvalid = 1'b1; e.rdata = bus.cache_rdata;
            end else if (bus.req_valid) begin
                e.stall = 1'b1;
            end
        end else if (!m_accepted) begin
            e.mval = 1'b1; e.mwe = m_is_store; e.maddr = m_addr;
            e.mwdata = m_is_store ? m_wdata : 32'h0;
            e.stall = m_is_store ? !bus.mem_req_ready : 1'b1;
        end else begin
            e.stall = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        exp_t e;
        e = model_out();
        if (!reset) begin
            m_started = 1'b1; m_pending = 1'b0; m_accepted = 1'b0; m_returning = 1'b0;
            m_misses = 0; m_stalls = 0;
        end else begin
            if (e.stall) m_stalls++;
            if (m_returning) begin
                m_returning = 1'b0;
            end else if (!m_pending) begin
                if (bus.req_valid && (bus.req_we || !bus.cache_hit)) begin
                    m_pending = 1'b1; m_accepted = 1'b0; m_is_store = bus.req_we;
                    m_addr = bus.req_addr; m_wdata = bus.req_wdata;
                    if (!bus.req_we) m_misses++;
                end
            end else if (!m_accepted) begin
                if (bus.mem_req_ready) begin
                    if (m_is_store) m_pending = 1'b0;
                    else m_accepted = 1'b1;
                end
            end else if (bus.mem_resp_valid) begin
                m_data = bus.mem_rdata; m_pending = 1'b0; m_returning = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (m_started) begin
            e = model_out();
            chk("stall", 32'(bus.stall), 32'(e.stall));
            chk("rdata_valid", 32'(bus.rdata_valid), 32'(e.rvalid));
            chk("rdata", bus.rdata, e.rdata);
            chk("cache_we", 32'(bus.cache_we), 32'(e.cwe));
            chk("fill_en", 32'(bus.fill_en), 32'(e.fen));
            chk("fill_addr", bus.fill_addr, e.faddr);
            chk("fill_data", bus.fill_data, e.fdata);
            chk("mem_req_valid", 32'(bus.mem_req_valid), 32'(e.mval));
            chk("mem_we", 32'(bus.mem_we), 32'(e.mwe));
            chk("mem_addr", bus.mem_addr, e.maddr);
            chk("mem_wdata", bus.mem_wdata, e.mwdata);
            chk("perf_misses", bus.perf_misses, PERF ? 32'(m_misses) : 32'h0);
            chk("perf_stall_cycles", bus.perf_stall_cycles, PERF ? 32'(m_stalls) : 32'h0);
        end
    end

    task automatic set_idle();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.cache_hit = 1'b0; bus.cache_rdata = '0; bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall"}, 32'(bus.stall), 32'h0);
        chk({tag, ".rdata_valid"}, 32'(bus.rdata_valid), 32'h0);
        chk({tag, ".rdata"}, bus.rdata, 32'h0);
        chk({tag, ".cache_we"}, 32'(bus.cache_we), 32'h0);
        chk({tag, ".fill_en"}, 32'(bus.fill_en), 32'h0);
        chk({tag, ".fill_addr"}, bus.fill_addr, 32'h0);
        chk({tag, ".fill_data"}, bus.fill_data, 32'h0);
        chk({tag, ".mem_req_valid"}, 32'(bus.mem_req_valid), 32'h0);
        chk({tag, ".mem_we"}, 32'(bus.mem_we), 32'h0);
        chk({tag, ".mem_addr"}, bus.mem_addr, 32'h0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata, 32'h0);
        chk({tag, ".perf_misses"}, bus.perf_misses, 32'h0);
        chk({tag, ".perf_stall"}, bus.perf_stall_cycles, 32'h0);
    endtask

    task automatic load_req(input logic [31:0] addr);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = addr; bus.cache_hit = 1'b0;
    endtask

    initial begin
        int stalls;
        int cwe_pulses;
        reset = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        cyc();
        reset = 1'b1;
        #1 chk_quiet("reset");

        // Read hit
        cyc();
        bus.req_valid = 1'b1; bus.req_addr = 32'h10; bus.cache_hit = 1'b1;
        bus.cache_rdata = 32'hDEADBEEF;
        #1;
        chk("hit.rdata", bus.rdata, 32'hDEADBEEF);
        chk("hit.rdata_valid", 32'(bus.rdata_valid), 32'h1);
        chk("hit.stall", 32'(bus.stall), 32'h0);
        chk("hit.mem_req_valid", 32'(bus.mem_req_valid), 32'h0);

        // Read miss at 0x40, ready high, response two cycles after the request
        cyc();
        load_req(32'h40); bus.mem_req_ready = 1'b1;
        #1 stalls = int'(bus.stall);
        cyc();
        #1 stalls += int'(bus.stall);
        chk("miss.mem_req_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("miss.mem_addr", bus.mem_addr, 32'h40);
        chk("miss.mem_we", 32'(bus.mem_we), 32'h0);
        cyc();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h12345678;
        #1 stalls += int'(bus.stall);
        cyc();
        bus.mem_resp_valid = 1'b0; bus.req_valid = 1'b0;
        #1;
        chk("miss.fill_en", 32'(bus.fill_en), 32'h1);
        chk("miss.fill_addr", bus.fill_addr, 32'h40);
        chk("miss.fill_data", bus.fill_data, 32'h12345678);
        chk("miss.rdata", bus.rdata, 32'h12345678);
        chk("miss.stall_in_fill", 32'(bus.stall), 32'h0);
        chk("miss.stall_len", 32'(stalls), 32'd3);
        chk("miss.perf_misses", bus.perf_misses, PERF ? 32'd1 : 32'd0);
        chk("miss.perf_stall", bus.perf_stall_cycles, PERF ? 32'd3 : 32'd0);

        // Reset while waiting for the read response; the late response must be dropped
        cyc();
        load_req(32'h40); bus.mem_req_ready = 1'b1;
        cyc();
        cyc();
        bus.req_valid = 1'b0; bus.mem_req_ready = 1'b0; reset = 1'b0;
        #1 chk("rst_mid.stall", 32'(bus.stall), 32'h1);
        cyc();
        #1 chk_quiet("rst_mid.in_reset");
        cyc();
        reset = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'hAAAA5555;
        #1 chk_quiet("rst_mid.stray_resp");
        cyc();
        bus.mem_resp_valid = 1'b0;
        #1 chk("rst_mid.no_fill", 32'(bus.fill_en), 32'h0);

        // Read miss with ready low for four cycles; the request address must not move
        cyc();
        load_req(32'h1000);
        #1 stalls = int'(bus.stall);
        for (int i = 0; i < 4; i++) begin
            cyc();
            bus.req_addr = $urandom;
            #1 stalls += int'(bus.stall);
            chk("rdy_low.mem_req_valid", 32'(bus.mem_req_valid), 32'h1);
            chk("rdy_low.mem_addr", bus.mem_addr, 32'h1000);
        end
        cyc();
        bus.mem_req_ready = 1'b1;
        #1 stalls += int'(bus.stall);
        cyc();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h0BADF00D;
        #1 stalls += int'(bus.stall);
        cyc();
        bus.mem_resp_valid = 1'b0; bus.req_valid = 1'b0;
        #1;
        chk("rdy_low.stall_len", 32'(stalls), 32'd7);
        chk("rdy_low.fill_data", bus.fill_data, 32'h0BADF00D);
        chk("rdy_low.perf_stall", bus.perf_stall_cycles, PERF ? 32'd7 : 32'd0);
        chk("rdy_low.perf_misses", bus.perf_misses, PERF ? 32'd1 : 32'd0);

        // Store with memory not ready for two cycles
        cyc();
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h80; bus.req_wdata = 32'hCAFEF00D;
        #1 cwe_pulses = int'(bus.cache_we);
        chk("st.stall_first", 32'(bus.stall), 32'h1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            bus.req_wdata = $urandom;
            #1 cwe_pulses += int'(bus.cache_we);
            chk("st.mem_we", 32'(bus.mem_we), 32'h1);
            chk("st.mem_wdata", bus.mem_wdata, 32'hCAFEF00D);
            chk("st.mem_addr", bus.mem_addr, 32'h80);
            chk("st.stall_wait", 32'(bus.stall), 32'h1);
        end
        cyc();
        bus.mem_req_ready = 1'b1;
        #1 cwe_pulses += int'(bus.cache_we);
        chk("st.stall_handshake", 32'(bus.stall), 32'h0);
        chk("st.mem_req_valid", 32'(bus.mem_req_valid), 32'h1);
        chk("st.cache_we_pulses", 32'(cwe_pulses), 32'd1);

        // Stray response in IDLE, then store immediately followed by a load miss
        cyc();
        bus.req_valid = 1'b0; bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1;
        bus.mem_rdata = 32'h99999999;
        #1 chk("stray.fill_en", 32'(bus.fill_en), 32'h0);
        cyc();
        bus.mem_resp_valid = 1'b0; bus.mem_req_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h84; bus.req_wdata = 32'h11112222;
        #1 chk("b2b.cache_we", 32'(bus.cache_we), 32'h1);
        cyc();
        #1 chk("b2b.wr_handshake_stall", 32'(bus.stall), 32'h0);
        chk("b2b.wr_mem_we", 32'(bus.mem_we), 32'h1);
        cyc();
        load_req(32'h44);
        #1 chk("b2b.ld_accept_stall", 32'(bus.stall), 32'h1);
        chk("b2b.ld_no_req_yet", 32'(bus.mem_req_valid), 32'h0);
        cyc();
        #1 chk("b2b.ld_mem_req", 32'(bus.mem_req_valid), 32'h1);
        chk("b2b.ld_mem_we", 32'(bus.mem_we), 32'h0);
        chk("b2b.ld_mem_addr", bus.mem_addr, 32'h44);
        cyc();
        bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b1; bus.mem_rdata = 32'h55556666;
        cyc();
        bus.mem_resp_valid = 1'b0; bus.req_valid = 1'b0;
        #1 chk("b2b.fill_data", bus.fill_data, 32'h55556666);
        chk("b2b.fill_addr", bus.fill_addr, 32'h44);

        // Random traffic, checked only by the per-cycle model comparison
        for (int i = 0; i < 4000; i++) begin
            cyc();
            reset              = ($urandom_range(0, 199) != 0);
            bus.req_valid      = ($urandom_range(0, 9) < 6);
            bus.req_we         = ($urandom_range(0, 2) == 0);
            bus.req_addr       = $urandom;
            bus.req_wdata      = $urandom;
            bus.cache_hit      = $urandom_range(0, 1) == 1;
            bus.cache_rdata    = $urandom;
            bus.mem_req_ready  = $urandom_range(0, 1) == 1;
            bus.mem_resp_valid = ($urandom_range(0, 3) == 0);
            bus.mem_rdata      = $urandom;
        end
        cyc();
        reset = 1'b1;
        set_idle();
        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
